// File: rtl/elementwise_division_serial.sv
// Serial element-wise unsigned divider: NUM_INSTANCES packed 2N/N divisions,
// one restoring step per cycle, results presented with a valid/ready handshake.
module elementwise_division_serial #(
  parameter int N             = 8,
  parameter int NUM_INSTANCES = 20
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [2*N*NUM_INSTANCES-1:0] a,
  input  logic [N*NUM_INSTANCES-1:0]   b,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [N*NUM_INSTANCES-1:0]   quotient,
  output logic [N*NUM_INSTANCES-1:0]   remainder,
  output logic [NUM_INSTANCES-1:0]     overflow
);

  localparam int IW = (NUM_INSTANCES > 1) ? $clog2(NUM_INSTANCES) : 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] CHECK  = 2'd1;
  localparam logic [1:0] DIVIDE = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_INSTANCES - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  logic [1:0]                   state_r;
  logic [IW-1:0]                idx_r;
  logic [CW-1:0]                cnt_r;
  logic [2*N*NUM_INSTANCES-1:0] a_r;
  logic [N*NUM_INSTANCES-1:0]   b_r;
  logic [N-1:0]                 prem_r;
  logic [N-1:0]                 src_r;
  logic [N-1:0]                 qacc_r;
  logic [N*NUM_INSTANCES-1:0]   q_work_r;
  logic [N*NUM_INSTANCES-1:0]   r_work_r;
  logic [NUM_INSTANCES-1:0]     ov_work_r;
  logic [N*NUM_INSTANCES-1:0]   quotient_r;
  logic [N*NUM_INSTANCES-1:0]   remainder_r;
  logic [NUM_INSTANCES-1:0]     overflow_r;
  logic                         in_ready_r;
  logic                         out_valid_r;

  logic [2*N-1:0]               a_cur_s;
  logic [N-1:0]                 b_cur_s;
  logic                         ovf_s;
  logic [N:0]                   trial_s;
  logic                         ge_s;
  logic [N-1:0]                 diff_s;
  logic [N-1:0]                 prem_next_s;
  logic [N:0]                   qshift_s;
  logic [N-1:0]                 qacc_next_s;
  logic                         elem_done_s;
  logic [N-1:0]                 elem_q_s;
  logic [N-1:0]                 elem_r_s;
  logic                         elem_ov_s;
  logic [N*NUM_INSTANCES-1:0]   q_next_s;
  logic [N*NUM_INSTANCES-1:0]   r_next_s;
  logic [NUM_INSTANCES-1:0]     ov_next_s;

  // Current element operands and one restoring-division step.
  always_comb begin
    a_cur_s     = a_r[int'(idx_r)*2*N +: 2*N];
    b_cur_s     = b_r[int'(idx_r)*N +: N];
    ovf_s       = (a_cur_s[2*N-1:N] >= b_cur_s);
    trial_s     = {prem_r, src_r[N-1]};
    ge_s        = (trial_s >= {1'b0, b_cur_s});
    // When ge_s holds the difference is below b, so N bits are enough.
    diff_s      = trial_s[N-1:0] - b_cur_s;
    prem_next_s = ge_s ? diff_s : trial_s[N-1:0];
    qshift_s    = {qacc_r, ge_s};
    qacc_next_s = qshift_s[N-1:0];
  end

  // Per-element result selection and merge into the working result vectors.
  always_comb begin
    elem_done_s = 1'b0;
    elem_q_s    = '0;
    elem_r_s    = '0;
    elem_ov_s   = 1'b0;
    case (state_r)
      CHECK: begin
        elem_done_s = ovf_s;
        elem_q_s    = {N{1'b1}};
        elem_r_s    = '0;
        elem_ov_s   = 1'b1;
      end
      DIVIDE: begin
        elem_done_s = (cnt_r == LAST_CNT);
        elem_q_s    = qacc_next_s;
        elem_r_s    = prem_next_s;
        elem_ov_s   = 1'b0;
      end
      default: begin
        elem_done_s = 1'b0;
      end
    endcase
    q_next_s  = q_work_r;
    r_next_s  = r_work_r;
    ov_next_s = ov_work_r;
    if (elem_done_s) begin
      q_next_s[int'(idx_r)*N +: N] = elem_q_s;
      r_next_s[int'(idx_r)*N +: N] = elem_r_s;
      ov_next_s[idx_r]             = elem_ov_s;
    end else begin
      q_next_s = q_work_r;
    end
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      idx_r       <= '0;
      cnt_r       <= '0;
      a_r         <= '0;
      b_r         <= '0;
      prem_r      <= '0;
      src_r       <= '0;
      qacc_r      <= '0;
      q_work_r    <= '0;
      r_work_r    <= '0;
      ov_work_r   <= '0;
      quotient_r  <= '0;
      remainder_r <= '0;
      overflow_r  <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      q_work_r  <= q_next_s;
      r_work_r  <= r_next_s;
      ov_work_r <= ov_next_s;
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_r        <= a;
            b_r        <= b;
            idx_r      <= '0;
            in_ready_r <= 1'b0;
            state_r    <= CHECK;
          end
        end
        CHECK: begin
          if (!ovf_s) begin
            prem_r  <= a_cur_s[2*N-1:N];
            src_r   <= a_cur_s[N-1:0];
            qacc_r  <= '0;
            cnt_r   <= '0;
            state_r <= DIVIDE;
          end
        end
        DIVIDE: begin
          prem_r <= prem_next_s;
          src_r  <= src_r << 1;
          qacc_r <= qacc_next_s;
          cnt_r  <= cnt_r + CW'(1);
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
      // Element finished: move to the next one or publish the whole vector.
      if (elem_done_s) begin
        if (idx_r == LAST_IDX) begin
          idx_r       <= '0;
          quotient_r  <= q_next_s;
          remainder_r <= r_next_s;
          overflow_r  <= ov_next_s;
          out_valid_r <= 1'b1;
          state_r     <= DONE;
        end else begin
          idx_r   <= idx_r + IW'(1);
          state_r <= CHECK;
        end
      end
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign quotient  = quotient_r;
  assign remainder = remainder_r;
  assign overflow  = overflow_r;

endmodule

// File: tb/tb_elementwise_division_serial.sv
// Scoreboard bench: a 2-element instance with directed vectors and a default
// 20-element instance with random operands checked against a == q*b + r.
module tb_elementwise_division_serial;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a;
  logic [15:0] b, quotient, remainder;
  logic [1:0]  overflow;

  logic         in_valid2, in_ready2, out_valid2, out_ready2;
  logic [319:0] a2;
  logic [159:0] b2, quotient2, remainder2;
  logic [19:0]  overflow2;

  always #5 clk = ~clk;

  elementwise_division_serial #(.N(8), .NUM_INSTANCES(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .quotient(quotient),
    .remainder(remainder), .overflow(overflow));

  elementwise_division_serial dut20 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .a(a2), .b(b2),
    .out_valid(out_valid2), .out_ready(out_ready2), .quotient(quotient2),
    .remainder(remainder2), .overflow(overflow2));

  typedef struct { logic [15:0] q; logic [15:0] r; logic [1:0] ov; int lat; } exp_t;
  typedef struct { logic [319:0] a; logic [159:0] b; int lat; } exp2_t;

  exp_t  sb[$];
  exp2_t sb2[$];
  int    acc_q[$];
  int    acc2_q[$];
  int    cyc = 0;
  int    checks = 0;
  int    fails = 0;
  bit    seen = 1'b0;
  bit    seen2 = 1'b0;
  exp_t  e_m;
  exp2_t e2_m;
  int    a0_m, a1_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Record accept cycles so monitors can measure latency.
  always @(posedge clk) begin
    if (rst) begin
      acc_q.delete();
      acc2_q.delete();
    end else begin
      if (in_valid && in_ready) acc_q.push_back(cyc + 1);
      if (in_valid2 && in_ready2) acc2_q.push_back(cyc + 1);
    end
    cyc <= cyc + 1;
  end

  // Monitor for the 2-element instance.
  always begin
    @(negedge clk);
    #1;
    if (!rst) begin
      if (out_valid && !seen) begin
        seen = 1'b1;
        if (sb.size() == 0 || acc_q.size() == 0) begin
          chk("unexpected_out_valid", 32'd1, 32'd0);
        end else begin
          a0_m = acc_q.pop_front();
          if (sb[0].lat >= 0) chk("latency", cyc - a0_m, sb[0].lat);
        end
      end
      if (out_valid && out_ready) begin
        seen = 1'b0;
        if (sb.size() > 0) begin
          e_m = sb.pop_front();
          chk("quotient", {16'd0, quotient}, {16'd0, e_m.q});
          chk("remainder", {16'd0, remainder}, {16'd0, e_m.r});
          chk("overflow", {30'd0, overflow}, {30'd0, e_m.ov});
        end
      end
    end
  end

  // Monitor for the 20-element instance: division identity or overflow rule.
  always begin
    @(negedge clk);
    #1;
    if (!rst) begin
      if (out_valid2 && !seen2) begin
        seen2 = 1'b1;
        if (sb2.size() == 0 || acc2_q.size() == 0) begin
          chk("unexpected_out_valid20", 32'd1, 32'd0);
        end else begin
          a1_m = acc2_q.pop_front();
          chk("latency20", cyc - a1_m, sb2[0].lat);
        end
      end
      if (out_valid2 && out_ready2) begin
        seen2 = 1'b0;
        if (sb2.size() > 0) begin
          e2_m = sb2.pop_front();
          for (int i = 0; i < 20; i++) begin
            logic [15:0] ai;
            logic [7:0]  bi, qi, ri;
            ai = e2_m.a[16*i +: 16];
            bi = e2_m.b[8*i +: 8];
            qi = quotient2[8*i +: 8];
            ri = remainder2[8*i +: 8];
            if (ai[15:8] >= bi) begin
              chk("elem20_ovf", {15'd0, overflow2[i], qi, ri}, {15'd0, 1'b1, 8'hFF, 8'h00});
            end else begin
              chk("elem20_identity", 32'(qi) * 32'(bi) + 32'(ri), {16'd0, ai});
              chk("elem20_rem_flag", {30'd0, overflow2[i], (ri < bi)}, 32'd1);
            end
          end
        end
      end
    end
  end

  task automatic send(input logic [31:0] av, input logic [15:0] bv, input logic [15:0] q,
                      input logic [15:0] r, input logic [1:0] ov, input int lat,
                      input bit expect_it);
    int k;
    k = 0;
    while (!in_ready && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
    if (expect_it) sb.push_back('{q, r, ov, lat});
    a = av;
    b = bv;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    a = 32'hDEAD_BEEF;
    b = 16'h5A5A;
  endtask

  task automatic wait_empty();
    int k;
    k = 0;
    while ((sb.size() != 0 || sb2.size() != 0) && k < 600) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0 || sb2.size() != 0) begin
      chk("completion_timeout", 32'd0, 32'd1);
      sb.delete();
      sb2.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int k;
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    in_valid2 = 1'b0; out_ready2 = 1'b1; a2 = '0; b2 = '0;
    @(negedge clk);
    chk("reset_quotient", {16'd0, quotient}, 32'd0);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_overflow", {30'd0, overflow}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);

    // Exact division, then a mixed-latency and a full-range vector.
    send(32'h0154_00FF, 16'h0201, 16'hAAFF, 16'h0000, 2'b00, 18, 1'b1);
    wait_empty();
    send(32'h0100_0005, 16'h0100, 16'hFFFF, 16'h0000, 2'b11, 2, 1'b1);
    wait_empty();
    send(32'h0005_1234, 16'h007F, 16'hFF24, 16'h0058, 2'b10, 10, 1'b1);
    wait_empty();
    send(32'h0001_FEFF, 16'hFFFF, 16'h00FF, 16'h01FE, 2'b00, 18, 1'b1);
    wait_empty();

    // Backpressure with the remainder vector.
    out_ready = 1'b0;
    send(32'h0155_0800, 16'h0240, 16'hAA20, 16'h0100, 2'b00, 18, 1'b1);
    k = 0;
    while (!out_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    for (int i = 0; i < 5; i++) begin
      chk("bp_quotient", {16'd0, quotient}, 32'h0000AA20);
      chk("bp_remainder", {16'd0, remainder}, 32'h00000100);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      in_valid = 1'b1;
      a = $urandom;
      b = 16'h0101;
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    chk("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
    wait_empty();

    // Reset during DIVIDE of element 1 discards the transaction.
    send(32'h0300_0006, 16'h3003, 16'h0, 16'h0, 2'b00, -1, 1'b0);
    repeat (11) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_quotient", {16'd0, quotient}, 32'd0);
    chk("midrst_remainder", {16'd0, remainder}, 32'd0);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (25) @(negedge clk);
    send(32'h0300_0006, 16'h3003, 16'h1002, 16'h0000, 2'b00, 18, 1'b1);
    wait_empty();

    // Default-size instance with random operands.
    for (int t = 0; t < 4; t++) begin
      int lat;
      lat = 0;
      for (int i = 0; i < 20; i++) begin
        logic [7:0] bi, hi;
        if (t == 0) begin
          bi = 8'($urandom_range(1, 255));
          hi = 8'($urandom_range(0, int'(bi) - 1));
        end else begin
          bi = 8'($urandom);
          hi = 8'($urandom);
        end
        b2[8*i +: 8]       = bi;
        a2[16*i + 8 +: 8]  = hi;
        a2[16*i +: 8]      = 8'($urandom);
        lat += (hi >= bi) ? 1 : 9;
      end
      k = 0;
      while (!in_ready2 && k < 400) begin
        @(negedge clk);
        k++;
      end
      sb2.push_back('{a2, b2, lat});
      in_valid2 = 1'b1;
      @(negedge clk);
      in_valid2 = 1'b0;
      a2 = '1;
      wait_empty();
    end

    $display("== %0d vectors applied, %0d miscompares ==", checks, fails);
    $finish;
  end

endmodule

// File: doc/elementwise_division_serial.md
ELEMENTWISE_DIVISION_SERIAL -- requirements
Module: elementwise_division_serial

Interface
REQ-001 SHALL have parameter N, default 8, meaning divisor/quotient/remainder element width in bits.
REQ-002 SHALL have parameter NUM_INSTANCES, default 20, meaning number of packed elements per transaction.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  operand vectors a/b valid.
REQ-006 SHALL have port in_ready  output  1  block can accept a transaction.
REQ-007 SHALL have port a  input  2*N*NUM_INSTANCES  packed dividends; element i at bits [2N*i +: 2N].
REQ-008 SHALL have port b  input  N*NUM_INSTANCES  packed divisors; element i at bits [N*i +: N].
REQ-009 SHALL have port out_valid  output  1  results valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts results.
REQ-011 SHALL have port quotient  output  N*NUM_INSTANCES  packed quotients; element i at [N*i +: N].
REQ-012 SHALL have port remainder  output  N*NUM_INSTANCES  packed remainders; element i at [N*i +: N].
REQ-013 SHALL have port overflow  output  NUM_INSTANCES  bit i set when element i quotient does not fit in N bits.

Function
REQ-014 SHALL implement FSM states IDLE, CHECK, DIVIDE, DONE.
REQ-015 SHALL assert in_ready only in IDLE; input accepted on edge with in_valid && in_ready; a and b captured into internal registers at that edge, later input changes ignored.
REQ-016 SHALL on accept clear element index to 0 and go IDLE -> CHECK.
REQ-017 SHALL in CHECK evaluate element i: overflow when a_i[2N-1:N] >= b_i (includes b_i == 0).
REQ-018 SHALL on overflow write quotient_i = all ones, remainder_i = 0, overflow[i] = 1, spending exactly 1 cycle on element i.
REQ-019 SHALL otherwise load partial remainder = a_i[2N-1:N], shift source = a_i[N-1:0], and go CHECK -> DIVIDE.
REQ-020 SHALL in DIVIDE perform one unsigned restoring step per cycle, exactly N cycles: shift in next dividend bit MSB-first, subtract b_i if result >= b_i, shift quotient bit in.
REQ-021 SHALL on final DIVIDE cycle write quotient_i, remainder_i (N bits, < b_i), overflow[i] = 0; non-overflow element costs N+1 cycles.
REQ-022 SHALL after element i increment index; if i == NUM_INSTANCES-1 go to DONE, else to CHECK.
REQ-023 SHALL satisfy a_i == quotient_i * b_i + remainder_i for every non-overflow element.
REQ-024 SHALL in DONE assert out_valid and hold quotient/remainder/overflow stable until out_valid && out_ready, then go DONE -> IDLE on that edge.
REQ-025 SHALL leave quotient/remainder/overflow holding the last completed transaction while in IDLE; out_valid = 0 outside DONE.
REQ-026 SHALL ignore in_valid while not in IDLE and ignore out_ready while not in DONE.
REQ-027 SHALL give latency from accept edge to out_valid high of sum over elements (1 if overflow else N+1) cycles; NUM_INSTANCES*(N+1) with no overflows.

Reset
REQ-028 SHALL on rst high, regardless of clock and state (including mid-DIVIDE or DONE), immediately force state IDLE, index 0, in_ready 1 after release, out_valid 0, quotient 0, remainder 0, overflow 0.
REQ-029 SHALL discard any in-flight transaction on reset; no partial result is ever presented with out_valid.

Verification (bench with N=8, NUM_INSTANCES=2 unless noted)
REQ-030 SHALL cover exact division: a={16'h0154,16'h00FF}, b={8'h02,8'h01} -> quotient={8'hAA,8'hFF}, remainder=0, overflow=2'b00, out_valid exactly 18 cycles after accept.
REQ-031 SHALL cover remainder: a={16'h0155,16'h0800}, b={8'h02,8'h40} -> quotient={8'hAA,8'h20}, remainder={8'h01,8'h00}, overflow=0.
REQ-032 SHALL cover overflow and zero divisor: a={16'h0100,16'h0005}, b={8'h01,8'h00} -> quotient={8'hFF,8'hFF}, remainder=0, overflow=2'b11, out_valid 2 cycles after accept.
REQ-033 SHALL cover backpressure: out_ready held 0 for 5 cycles in DONE -> outputs stable, in_ready 0, new in_valid ignored; out_ready=1 -> IDLE next cycle, in_ready 1.
REQ-034 SHALL cover reset mid-operation: rst pulsed during DIVIDE of element 1 -> outputs 0 immediately, out_valid never asserts; next transaction a={16'h0300,16'h0006}, b={8'h30,8'h03} -> quotient={8'h10,8'h02}, remainder=0.
REQ-035 SHALL cover defaults N=8, NUM_INSTANCES=20 with randomized operands checked against a == q*b + r or overflow rule, and latency per REQ-027.
